// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the forwarding / hazard control unit.
// Optional statistics counters are enabled with FWD_STATS_EN.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } fwd_state_t;

    localparam int FWD_RF = 0;

    function automatic int fwd_alu(input int k);
        return 2 * k + 1;
    endfunction

    function automatic int fwd_lui(input int k);
        return 2 * k + 2;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: nearest matching writer stage wins.
// Register 0 is never forwarded.
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int NSTG    = 2,
    parameter int REGBITS = 5,
    parameter int SELW    = $clog2(2 * NSTG + 1)
) (
    input  logic [REGBITS-1:0]      i_src,
    input  logic [NSTG-1:0]         i_regwr,
    input  logic [NSTG*REGBITS-1:0] i_wsel,
    input  logic [NSTG-1:0]         i_lui,
    output logic [SELW-1:0]         o_sel
);

    // Scan far-to-near so the nearest hit is the last assignment.
    always_comb begin
        o_sel = SELW'(FWD_RF);
        if (i_src != '0) begin
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (i_regwr[k] &&
                    i_wsel[k*REGBITS +: REGBITS] == i_src) begin
                    o_sel = i_lui[k] ? SELW'(fwd_lui(k))
                                     : SELW'(fwd_alu(k));
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus load-use stall / memory-wait freeze control.
// Define FWD_STATS_EN to build the stall and freeze cycle counters.
module fwd_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int NSTG     = 2,
    parameter int REGBITS  = 5,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(2 * NSTG + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NSRC*REGBITS-1:0] ex_src,
    input  logic [NSRC*REGBITS-1:0] id_src,
    input  logic                    id_valid,
    input  logic                    ex_memread,
    input  logic [REGBITS-1:0]      ex_wsel,
    input  logic [NSTG-1:0]         stg_regwr,
    input  logic [NSTG*REGBITS-1:0] stg_wsel,
    input  logic [NSTG-1:0]         stg_lui,
    input  logic                    mem_req,
    input  logic                    dhit,
    output logic [NSRC*SELW-1:0]    fwd_sel,
    output logic                    stall_id,
    output logic                    freeze,
    output logic [31:0]             lu_cnt_o,
    output logic [31:0]             mw_cnt_o
);

    localparam logic [2:0] LL_M1 = 3'(LOAD_LAT - 1);

    fwd_state_t r_state;
    fwd_state_t w_state_nx;
    logic [2:0] r_lu_left;
    logic [2:0] w_lu_left_nx;
    logic       w_id_match;
    logic       w_hz;
    logic       w_frz;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_select #(
            .NSTG    (NSTG),
            .REGBITS (REGBITS),
            .SELW    (SELW)
        ) u_sel (
            .i_src   (ex_src[i*REGBITS +: REGBITS]),
            .i_regwr (stg_regwr),
            .i_wsel  (stg_wsel),
            .i_lui   (stg_lui),
            .o_sel   (fwd_sel[i*SELW +: SELW])
        );
    end

    always_comb begin
        w_id_match = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src[i*REGBITS +: REGBITS] == ex_wsel)
                w_id_match = 1'b1;
        end
    end

    assign w_hz  = id_valid & ex_memread & (ex_wsel != '0) & w_id_match;
    assign w_frz = mem_req & ~dhit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_lu_left <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_lu_left <= w_lu_left_nx;
        end
    end

    // lu_left doubles as the saved return state across a freeze.
    always_comb begin
        w_state_nx   = r_state;
        w_lu_left_nx = r_lu_left;
        if (w_frz) begin
            w_state_nx = MEM_WAIT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hz) begin
                        w_lu_left_nx = LL_M1;
                        w_state_nx   = (LOAD_LAT > 1) ? LU_STALL : IDLE;
                    end
                end
                LU_STALL: begin
                    if (r_lu_left != '0)
                        w_lu_left_nx = r_lu_left - 3'd1;
                    if (r_lu_left <= 3'd1)
                        w_state_nx = IDLE;
                end
                MEM_WAIT: begin
                    w_state_nx = (r_lu_left != '0) ? LU_STALL : IDLE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_id = 1'b0;
        freeze   = 1'b0;
        if (!RST) begin
            if (w_frz) begin
                freeze = 1'b1;
            end else begin
                case (r_state)
                    IDLE:     stall_id = w_hz;
                    LU_STALL: stall_id = 1'b1;
                    default:  stall_id = 1'b0;
                endcase
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_mw_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lu_cnt <= '0;
            r_mw_cnt <= '0;
        end else begin
            if (stall_id && r_lu_cnt != '1)
                r_lu_cnt <= r_lu_cnt + 32'd1;
            if (freeze && r_mw_cnt != '1)
                r_mw_cnt <= r_mw_cnt + 32'd1;
        end
    end

    assign lu_cnt_o = r_lu_cnt;
    assign mw_cnt_o = r_mw_cnt;
`else
    assign lu_cnt_o = '0;
    assign mw_cnt_o = '0;
`endif

endmodule
